hub_poll_scheduler: RTL
=======================

# hub_poll_scheduler

Sequences periodic status polling of the hub's downstream ports and collects their status-change bits into one hub change bitmap for the upstream interrupt endpoint. It owns the poll interval timer, visits each enabled port once per sweep over a per-port request/response pair, and presents the accumulated bitmap on a valid/ready handshake. It sits between the downstream port controllers and the upstream interrupt-IN logic.

## Interface
- NUM_PORTS, 4, number of downstream ports, 2..15
- POLL_PERIOD, 100, clock cycles between sweep starts, ≥ 4
- TIMEOUT, 16, cycles to wait for a port response (only with timeout feature)
- clock  input  1  single clock, all logic on posedge
- reset  input  1  synchronous, active-high
- port_enable  input  NUM_PORTS  port powered/configured; disabled ports skipped
- poll_req  output  NUM_PORTS  one-hot, one-cycle status request to a port
- port_rsp_valid  input  NUM_PORTS  port answers its poll
- port_rsp_change  input  NUM_PORTS  status changed, qualified by port_rsp_valid
- bitmap  output  NUM_PORTS  change bitmap, bit i = port i
- bitmap_valid  output  1  bitmap available
- bitmap_ready  input  1  upstream consumes bitmap
- sweep_overrun  output  1  one-cycle pulse: tick arrived while sweep active
- port_timeout  output  NUM_PORTS  one-hot one-cycle pulse: port failed to answer

## Operation
- Reset: all outputs 0, tick counter 0, accumulator and pending cleared, FSM IDLE.
- Tick counter free-runs 0..POLL_PERIOD-1; tick when counter = POLL_PERIOD-1, then wraps to 0.
- FSM states: IDLE, POLL, WAIT, DONE.
- IDLE: on tick with port_enable ≠ 0 → POLL at lowest enabled index; with port_enable = 0 tick ignored (no overrun).
- POLL: poll_req[cur] = 1 for one cycle → WAIT.
- WAIT: accept only port_rsp_valid[cur]; responses from other ports ignored. On accept, OR port_rsp_change[cur] into accumulator, advance to next enabled index above cur; none left → DONE, else → POLL.
- WAIT with port_enable[cur] dropping: abort, no change bit, advance as above.
- DONE: if accumulator ≠ 0 and bitmap_valid = 0, load bitmap, set bitmap_valid, clear accumulator; otherwise keep accumulator for the next sweep. → IDLE.
- Handshake: bitmap and bitmap_valid stable while bitmap_valid & !bitmap_ready; valid & ready clears bitmap_valid next edge.
- Tick in any state other than IDLE: sweep_overrun pulses, tick dropped, counter still wraps.
- Enabled set sampled per step, not latched at sweep start; a port enabled mid-sweep is visited if its index is above cur.

## Timing
- Tick in cycle t (IDLE) → poll_req high in cycle t+1.
- port_rsp_valid sampled from cycle t+2 (cycle after poll_req); response during the poll_req cycle ignored.
- Response accepted in cycle r → next poll_req in r+1; if last port, DONE in r+1, bitmap_valid high in r+2.
- Response and timeout expiry in the same cycle: response wins, no port_timeout.
- Reset mid-sweep: next cycle all outputs 0, FSM IDLE, accumulated bits discarded.

## Configuration
- HUB_POLL_SCHED_TIMEOUT_EN defined: WAIT counter starts at 0 on WAIT entry; after TIMEOUT cycles without response, port_timeout[cur] pulses one cycle, no change bit, advance as on response.
- Not defined: WAIT holds indefinitely until response or port disable; port_timeout tied to 0; TIMEOUT unused.

## Structure
- Shared hub package: FSM state enum (IDLE, POLL, WAIT, DONE), port-index width function, default POLL_PERIOD/TIMEOUT constants.
- One sub-module: hub_next_port_sel, combinational priority select of lowest enabled index strictly above cur (or lowest overall from IDLE), plus none-left flag.

## Test plan
- NUM_PORTS=4, POLL_PERIOD=20, all enabled, port 2 answers change=1, others 0, each 1 cycle after poll_req → bitmap=4'b0100, bitmap_valid 2 cycles after port 3 response.
- port_enable=4'b1010 → poll_req only 4'b0010 then 4'b1000 per sweep; port_enable=0 → no poll_req, no overrun over 3 periods.
- bitmap_ready held 0 for 2 sweeps with port 0 then port 1 changes → bitmap stays 4'b0001; after ready, next sweep end publishes 4'b0010.
- Port 1 never answers, HUB_POLL_SCHED_TIMEOUT_EN defined, TIMEOUT=16 → port_timeout=4'b0010 once, sweep continues to port 2; undefined → FSM stays WAIT, sweep_overrun pulses each tick.
- Port responses delayed 10 cycles each, POLL_PERIOD=20 → sweep_overrun pulses at the tick falling mid-sweep; that tick starts no new sweep.
- Reset asserted in WAIT with accumulator nonzero → all outputs 0 next cycle, first post-reset poll_req at tick+1.

Source files
------------

// File: rtl/hub_poll_scheduler_pkg.sv
// Shared hub definitions: poll FSM states, port-index width helper, default timing constants.
package hub_poll_scheduler_pkg;

  localparam int unsigned DEF_POLL_PERIOD = 100;
  localparam int unsigned DEF_TIMEOUT     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POLL = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } hub_state_e;

  // Bits needed to index n ports (at least one).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub_next_port_sel.sv
// Priority select of the lowest enabled port strictly above cur, or lowest overall when
// starting a sweep from idle; none_left_c flags an exhausted sweep.
module hub_next_port_sel
  import hub_poll_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] port_enable,
  input  logic [IDX_W-1:0]     cur,
  input  logic                 from_idle,
  output logic [IDX_W-1:0]     next_idx_c,
  output logic                 none_left_c
);

  // Scan downward so the lowest qualifying index is the last one written.
  always_comb begin
    next_idx_c  = '0;
    none_left_c = 1'b1;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_enable[i] && (from_idle || (IDX_W'(i) > cur))) begin
        next_idx_c  = IDX_W'(i);
        none_left_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hub_poll_scheduler.sv
// Periodic downstream-port status poller building the hub change bitmap for interrupt-IN.
// Optional response timeout enabled by defining HUB_POLL_SCHED_TIMEOUT_EN.
module hub_poll_scheduler
  import hub_poll_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned POLL_PERIOD = DEF_POLL_PERIOD
`ifdef HUB_POLL_SCHED_TIMEOUT_EN
  , parameter int unsigned TIMEOUT   = DEF_TIMEOUT
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] port_enable,
  output logic [NUM_PORTS-1:0] poll_req,
  input  logic [NUM_PORTS-1:0] port_rsp_valid,
  input  logic [NUM_PORTS-1:0] port_rsp_change,
  output logic [NUM_PORTS-1:0] bitmap,
  output logic                 bitmap_valid,
  input  logic                 bitmap_ready,
  output logic                 sweep_overrun,
  output logic [NUM_PORTS-1:0] port_timeout
);

  localparam int unsigned IDX_W = idx_w(NUM_PORTS);
  localparam int unsigned CNT_W = $clog2(POLL_PERIOD);
  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(POLL_PERIOD - 1);

  hub_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [NUM_PORTS-1:0] acc_q, acc_d;
  logic [NUM_PORTS-1:0] poll_req_q, poll_req_d;
  logic [NUM_PORTS-1:0] bitmap_q, bitmap_d;
  logic                 bitmap_valid_q, bitmap_valid_d;
  logic                 sweep_overrun_q, sweep_overrun_d;
  logic [NUM_PORTS-1:0] port_timeout_q, port_timeout_d;
  logic                 tick_c;
  logic                 advance_c;
  logic [IDX_W-1:0]     next_idx_c;
  logic                 none_left_c;

`ifdef HUB_POLL_SCHED_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Cycles spent in WAIT for the current port; zero on every WAIT entry.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`endif

  hub_next_port_sel #(.NUM_PORTS(NUM_PORTS)) u_next_sel (
    .port_enable (port_enable),
    .cur         (cur_q),
    .from_idle   (state_q == IDLE),
    .next_idx_c  (next_idx_c),
    .none_left_c (none_left_c)
  );

  // Interval timer, sweep sequencing, accumulation and upstream handshake.
  always_comb begin
    tick_c          = (cnt_q == TICK_AT);
    cnt_d           = tick_c ? '0 : cnt_q + 1'b1;
    state_d         = state_q;
    cur_d           = cur_q;
    acc_d           = acc_q;
    poll_req_d      = '0;
    bitmap_d        = bitmap_q;
    bitmap_valid_d  = bitmap_valid_q;
    sweep_overrun_d = tick_c && (state_q != IDLE);
    port_timeout_d  = '0;
    advance_c       = 1'b0;

    if (bitmap_valid_q && bitmap_ready) bitmap_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick_c && (|port_enable)) begin
          state_d    = POLL;
          cur_d      = next_idx_c;
          poll_req_d = NUM_PORTS'(1) << next_idx_c;
        end
      end
      POLL: state_d = WAIT;
      WAIT: begin
        // A response beats both a disable and a timeout expiring in the same cycle.
        if (port_rsp_valid[cur_q]) begin
          acc_d     = acc_q | (NUM_PORTS'(port_rsp_change[cur_q]) << cur_q);
          advance_c = 1'b1;
        end else if (!port_enable[cur_q]) begin
          advance_c = 1'b1;
`ifdef HUB_POLL_SCHED_TIMEOUT_EN
        end else if (wait_cnt_q == WAIT_LAST) begin
          port_timeout_d = NUM_PORTS'(1) << cur_q;
          advance_c      = 1'b1;
`endif
        end
      end
      DONE: begin
        // Publish only into an empty slot; otherwise carry the bits into the next sweep.
        if ((|acc_q) && !bitmap_valid_q) begin
          bitmap_d       = acc_q;
          bitmap_valid_d = 1'b1;
          acc_d          = '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance_c) begin
      if (none_left_c) begin
        state_d = DONE;
      end else begin
        state_d    = POLL;
        cur_d      = next_idx_c;
        poll_req_d = NUM_PORTS'(1) << next_idx_c;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      cur_q           <= '0;
      acc_q           <= '0;
      poll_req_q      <= '0;
      bitmap_q        <= '0;
      bitmap_valid_q  <= 1'b0;
      sweep_overrun_q <= 1'b0;
      port_timeout_q  <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cur_q           <= cur_d;
      acc_q           <= acc_d;
      poll_req_q      <= poll_req_d;
      bitmap_q        <= bitmap_d;
      bitmap_valid_q  <= bitmap_valid_d;
      sweep_overrun_q <= sweep_overrun_d;
      port_timeout_q  <= port_timeout_d;
    end
  end

  assign poll_req      = poll_req_q;
  assign bitmap        = bitmap_q;
  assign bitmap_valid  = bitmap_valid_q;
  assign sweep_overrun = sweep_overrun_q;
  assign port_timeout  = port_timeout_q;

endmodule
